// File: rtl/multibyte_pkg.sv
// Shared types and constants for the byte-serial multi-byte adder sequencer.
package multibyte_pkg;
    localparam int BYTE_W    = 8;
    localparam int MAX_BYTES = 16;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [BYTE_W-1:0] sum;
        logic              last;
        logic              carry;
        logic              ovf;
    } beat_t;
endpackage

// File: rtl/adder_8bit.sv
// Plain 8-bit ripple-carry adder, one full-adder cell per bit.
module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    output logic [7:0] sum,
    output logic       carry_out
);
    logic c;

    always_comb begin
        c   = carry_in;
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carry_out = c;
    end
endmodule

// File: rtl/multibyte_add_seq.sv
// Streams NUM_BYTES operand byte pairs LSB-first through one 8-bit adder,
// chaining carry in a register and emitting one registered result byte per input.
module multibyte_add_seq
    import multibyte_pkg::*;
#(
    parameter int NUM_BYTES = 4,
    parameter int CNT_W     = $clog2(NUM_BYTES) + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       abort,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       in_sub,
    input  logic       in_cin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_sum,
    output logic       out_last,
    output logic       out_carry,
    output logic       out_ovf,
    output logic       busy
);
    state_t           state, state_nxt;
    logic [CNT_W-1:0] byte_cnt, cnt_nxt;
    logic             carry_q, carry_nxt;
    logic             mode_q, mode_nxt;
    logic             first, sub_eff, accept, last;
    logic [7:0]       b_eff, add_sum;
    logic             add_cin, add_cout;
    beat_t            beat_nxt;

    // One-entry output register: a new byte may enter as the old one drains.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !abort;
    assign busy     = (state == RUN) || out_valid;

    assign first   = (state == IDLE);
    assign sub_eff = first ? in_sub : mode_q;
    assign b_eff   = in_b ^ {8{sub_eff}};
    assign add_cin = first ? (sub_eff ? 1'b1 : in_cin) : carry_q;

    adder_8bit u_adder (
        .a        (in_a),
        .b        (b_eff),
        .carry_in (add_cin),
        .sum      (add_sum),
        .carry_out(add_cout)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = byte_cnt;
        carry_nxt = carry_q;
        mode_nxt  = mode_q;
        last      = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            carry_nxt = 1'b0;
        end else if (accept) begin
            carry_nxt = add_cout;
            case (state)
                IDLE: begin
                    mode_nxt = in_sub;
                    if (NUM_BYTES == 1) begin
                        last    = 1'b1;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (byte_cnt == CNT_W'(NUM_BYTES - 1)) begin
                        last      = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = byte_cnt + CNT_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Carry and overflow only mean anything on the most-significant byte.
    always_comb begin
        beat_nxt.sum   = add_sum;
        beat_nxt.last  = last;
        beat_nxt.carry = last && add_cout;
        beat_nxt.ovf   = last && (in_a[7] == b_eff[7]) && (add_sum[7] != in_a[7]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            byte_cnt <= '0;
            carry_q  <= 1'b0;
            mode_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= cnt_nxt;
            carry_q  <= carry_nxt;
            mode_q   <= mode_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            {out_sum, out_last, out_carry, out_ovf} <= '0;
        end else if (abort) begin
            out_valid <= 1'b0;
            {out_sum, out_last, out_carry, out_ovf} <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            {out_sum, out_last, out_carry, out_ovf} <= beat_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_multibyte_add_seq.sv
// Bench for multibyte_add_seq: whole-word arithmetic reference model feeding an
// expected-beat queue, directed corner cases, then randomized traffic with backpressure.
module tb_multibyte_add_seq;
    localparam int NB = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       in_sub = 1'b0;
    logic       in_cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_sum;
    logic       out_last, out_carry, out_ovf, busy;

    int n_chk  = 0;
    int n_fail = 0;
    logic chk_en = 1'b1;
    logic bp_en  = 1'b0;
    logic [10:0] exp_q[$];

    multibyte_add_seq #(.NUM_BYTES(NB)) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_sub(in_sub), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_last(out_last), .out_carry(out_carry), .out_ovf(out_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Result from whole-word arithmetic: {ovf, carry, result[31:0]}.
    function automatic logic [33:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub, input logic cin);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint s, ex;
        logic c, o;
        if (sub) begin
            s  = sa - sb;
            ex = ua - ub;
            c  = (ua >= ub);
        end else begin
            s  = sa + sb + longint'(cin);
            ex = ua + ub + longint'(cin);
            c  = (ex >= 64'h1_0000_0000);
        end
        o = (s > SMAX) || (s < SMIN);
        return {o, c, ex[31:0]};
    endfunction

    task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin);
        logic [33:0] r = ref_op(a, b, sub, cin);
        for (int i = 0; i < NB; i++)
            exp_q.push_back({r[8*i +: 8], i == NB-1, (i == NB-1) && r[32], (i == NB-1) && r[33]});
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte was taken.
    task automatic send_byte(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin);
        bit got = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_cin = cin;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!got) chk("accept_timeout", 0, 1);
        else chk("latency_out_valid", out_valid, 1);
    endtask

    task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                           input logic cin, input bit gaps);
        push_op(a, b, sub, cin);
        for (int i = 0; i < NB; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk) #1;
            // Mode and carry-in after the first byte must be ignored.
            if (i == 0) send_byte(a[8*i +: 8], b[8*i +: 8], sub, cin);
            else        send_byte(a[8*i +: 8], b[8*i +: 8], 1'($urandom), 1'($urandom));
        end
    endtask

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_beat", {out_sum, out_last, out_carry, out_ovf}, 'x);
                else chk("beat", {out_sum, out_last, out_carry, out_ovf}, exp_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [31:0] ra, rb;
        // Hand-computed anchors for the reference model.
        chk("model_add_ff_1",   ref_op(32'h000000FF, 32'h00000001, 0, 0), {2'b00, 32'h00000100});
        chk("model_add_cin",    ref_op(32'hFFFFFFFF, 32'h00000000, 0, 1), {2'b01, 32'h00000000});
        chk("model_sub_borrow", ref_op(32'h00000000, 32'h00000001, 1, 0), {2'b00, 32'hFFFFFFFF});
        chk("model_sub_ovf",    ref_op(32'h80000000, 32'h00000001, 1, 0), {2'b11, 32'h7FFFFFFF});
        chk("model_add_ovf",    ref_op(32'h7FFFFFFF, 32'h00000001, 0, 0), {2'b10, 32'h80000000});
        chk("model_add_plain",  ref_op(32'h01020304, 32'h01010101, 0, 0), {2'b00, 32'h02030405});

        #12;
        chk("reset_outputs", {out_valid, out_sum, out_last, out_carry, out_ovf, busy, in_ready}, 14'h0001);
        rst = 1'b0;
        @(posedge clk) #1;

        send_op(32'h000000FF, 32'h00000001, 0, 0, 0);
        send_op(32'hFFFFFFFF, 32'h00000000, 0, 1, 0);
        send_op(32'h00000000, 32'h00000001, 1, 0, 0);
        send_op(32'h80000000, 32'h00000001, 1, 0, 0);
        send_op(32'h7FFFFFFF, 32'h00000001, 0, 0, 0);

        // Backpressure: hold output for three cycles after the first byte.
        push_op(32'h12345678, 32'h11111111, 0, 0);
        send_byte(8'h78, 8'h11, 0, 0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'h56; in_b = 8'h11;
        repeat (3) begin
            @(negedge clk);
            chk("stall_hold", {out_valid, out_sum, in_ready}, {1'b1, 8'h89, 1'b0});
        end
        @(posedge clk) #1;
        out_ready = 1'b1;
        send_byte(8'h56, 8'h11, 0, 0);
        send_byte(8'h34, 8'h11, 1, 1);
        send_byte(8'h12, 8'h11, 1, 0);

        // Async reset mid-cycle after two bytes.
        push_op(32'hAABBCCDD, 32'h11223344, 0, 0);
        send_byte(8'hDD, 8'h44, 0, 0);
        send_byte(8'hCC, 8'h33, 0, 0);
        #2 rst = 1'b1;
        #1 chk("rst_midop", {out_valid, out_sum, out_last, out_carry, out_ovf, busy}, 13'h0);
        exp_q.delete();
        rst = 1'b0;
        @(posedge clk) #1;

        // Abort after one byte; the same-cycle input must be ignored.
        push_op(32'h55555555, 32'h22222222, 1, 0);
        send_byte(8'h55, 8'h22, 1, 0);
        chk_en = 1'b0; out_ready = 1'b0;
        abort = 1'b1; in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF;
        @(posedge clk) #1;
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_clear", {out_valid, out_sum, busy}, 10'h0);
        exp_q.delete();
        out_ready = 1'b1; chk_en = 1'b1;
        send_op(32'h01020304, 32'h01010101, 0, 0, 0);

        // Randomized traffic with gaps and output backpressure.
        bp_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
                0: ra = 32'h0;
                1: ra = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                3: ra = 32'h7FFFFFFF;
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            send_op(ra, rb, 1'($urandom), 1'($urandom), 1);
        end
        @(posedge clk);
        bp_en = 1'b0;
        #2 out_ready = 1'b1;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
        chk("idle_at_end", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multibyte_add_seq.md
Name: multibyte_add_seq

Overview:
- Sequencer that performs NUM_BYTES-wide add/subtract by streaming operand byte pairs, LSB first, through one 8-bit ripple adder (adder_8bit).
- Sits directly upstream of adder_8bit. It drives a, b and carry_in, and consumes sum and carry_out.
- It chains the carry between bytes in a register and presents result bytes on a registered valid/ready output, with final carry and signed-overflow flags.

Parameters:
- NUM_BYTES, 4, operand width in bytes. Legal range is 1..16.
- CNT_W, $clog2(NUM_BYTES)+1, byte-counter width (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- abort  in  1  synchronous operation cancel.
- in_valid  in  1  operand byte pair valid.
- in_ready  out  1  sequencer can accept a byte pair.
- in_a  in  8  operand A byte.
- in_b  in  8  operand B byte.
- in_sub  in  1  1 = A−B, 0 = A+B. Sampled on first byte only.
- in_cin  in  1  external carry-in for add. Sampled on first byte only; ignored when in_sub=1.
- out_valid  out  1  result byte valid.
- out_ready  in  1  downstream accepts result byte.
- out_sum  out  8  result byte.
- out_last  out  1  result byte is the most-significant byte.
- out_carry  out  1  final carry-out (1 = no borrow in subtract). Meaningful only with out_last.
- out_ovf  out  1  signed overflow. Meaningful only with out_last.
- busy  out  1  operation in progress (state RUN or out_valid).

Behaviour:
- Reset (async, rst=1): state=IDLE, byte_cnt=0, carry_q=0, mode_q=0, out_valid=0, out_sum=0, out_last=0, out_carry=0, out_ovf=0. Reset mid-operation discards partial results, with no output beat.
- Handshake:
  - Input accepted when in_valid && in_ready.
  - Output transferred when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (one-entry output register; accept and drain in the same cycle allowed).
  - in_ready is combinational from out_ready only, never from in_valid.
- Adder drive:
  - a=in_a.
  - b = in_b ^ {8{sub_eff}}.
  - carry_in = first byte ? (sub_eff ? 1 : in_cin) : carry_q.
  - sub_eff = first byte ? in_sub : mode_q.
- Latency: a byte pair accepted in cycle N appears on out_sum with out_valid=1 from cycle N+1.
- FSM:
  - IDLE: accept → latch mode_q=in_sub, carry_q=carry_out, byte_cnt=1.
    - NUM_BYTES==1: out_last=1 and stay IDLE.
    - Otherwise: go to RUN.
  - RUN: accept → carry_q=carry_out, byte_cnt+1.
    - Accepting byte NUM_BYTES−1: out_last=1, byte_cnt=0, go to IDLE.
- On the last byte:
  - out_carry = adder carry_out.
  - out_ovf = (in_a[7] == b[7]) && (sum[7] != in_a[7]), using inverted b in subtract.
  - Non-last bytes drive out_carry=0 and out_ovf=0.
- Output register:
  - Holds out_sum/out_last/out_carry/out_ovf stable while out_valid && !out_ready.
  - Clears out_valid on transfer without a new accept.
- abort (priority over accept; same-cycle in_valid ignored): state=IDLE, byte_cnt=0, carry_q=0, out_valid=0. Any pending output byte is dropped.
- Operands are unsigned or two's-complement; wrap-around is modulo 2^(8·NUM_BYTES), with no saturation.

Decomposition:
- Shared package multibyte_pkg:
  - state enum {IDLE, RUN}.
  - Constants BYTE_W=8 and MAX_BYTES=16.
- One sub-module: adder_8bit, instantiated as is. Its ports are a, b, carry_in, sum and carry_out.
- No other hierarchy.

Test Plan:
- Add, NUM_BYTES=4, 0x000000FF+0x00000001, cin=0, out_ready=1 → bytes 00,01,00,00; out_last on 4th; carry=0; ovf=0; one byte per cycle, latency 1.
- Add 0xFFFFFFFF+0x00000000 with cin=1 → 00,00,00,00; out_carry=1; ovf=0.
- Subtract 0x00000000−0x00000001 → FF,FF,FF,FF; out_carry=0 (borrow); ovf=0. Then subtract 0x80000000−0x00000001 → FF,FF,FF,7F; ovf=1.
- Add 0x7FFFFFFF+0x00000001 → 00,00,00,80; out_ovf=1; out_carry=0.
- Backpressure: out_ready=0 for 3 cycles after byte 1 → out_valid held, out_sum stable, in_ready=0. The final result matches the no-stall case and no byte is duplicated or lost.
- Assert rst (async, mid-clock) after byte 2 of 4, then abort in another run after byte 1 → all outputs 0 immediately, busy=0. The next full operation 0x01020304+0x01010101 yields 05,04,03,02.
